// File: rtl/inst_fifo_pkg.sv
// Shared fetch/decode types for the dual-issue instruction buffer.
package inst_fifo_pkg;

    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        tlb_miss;
        logic        tlb_illegal;
        logic        tlb_invalid;
    } fetch_entry_t;

    // Number of slots taken in one cycle; slot 2 is only ever set alongside slot 1.
    function automatic logic [$clog2(FETCH_WIDTH+1)-1:0] slots_taken(input logic s1, input logic s2);
        return {1'b0, s1} + {1'b0, s2};
    endfunction

endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/decode side bundle of the instruction buffer; master drives, slave is the buffer.
interface inst_fifo_if #(
    parameter int DEPTH = 16
) ();
    import inst_fifo_pkg::*;

    logic                     flush;
    logic                     write_en1;
    logic                     write_en2;
    fetch_entry_t             write_data1;
    fetch_entry_t             write_data2;
    logic                     read_en1;
    logic                     read_en2;
    fetch_entry_t             read_data1;
    fetch_entry_t             read_data2;
    logic                     read_valid1;
    logic                     read_valid2;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, write_en1, write_en2, write_data1, write_data2, read_en1, read_en2,
        input  read_data1, read_data2, read_valid1, read_valid2, empty, full, count
    );

    modport slave (
        input  flush, write_en1, write_en2, write_data1, write_data2, read_en1, read_en2,
        output read_data1, read_data2, read_valid1, read_valid2, empty, full, count
    );

endinterface

// File: rtl/inst_fifo_ram.sv
// Instruction buffer storage: two write ports at consecutive addresses, two async read ports.
module fifo_ram
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we1_i,
    input  logic          we2_i,
    input  logic [AW-1:0] waddr_i,
    input  fetch_entry_t  wdata1_i,
    input  fetch_entry_t  wdata2_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output fetch_entry_t  rdata1_o,
    output fetch_entry_t  rdata2_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] waddr2;

    assign waddr2 = waddr_i + AW'(1);

    always_ff @(posedge clk_i) begin
        if (we1_i) mem_q[waddr_i] <= wdata1_i;
        if (we2_i) mem_q[waddr2]  <= wdata2_i;
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction buffer between fetch and decode: show-ahead head/head+1,
// up to two writes and two retires per cycle, flush on redirect.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    inst_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_DEPTH_M1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_TWO      = CNT_W'(2);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_acc1, wr_acc2;
    logic             rd_acc1, rd_acc2;
    logic [1:0]       n_wr, n_rd;
    logic [PTR_W-1:0] head_p1;
    fetch_entry_t     ram_rd1, ram_rd2;

    // Acceptance looks only at the registered count; same-cycle reads never make room.
    always_comb begin
        wr_acc1 = bus.write_en1 && (count_q < CNT_DEPTH);
        wr_acc2 = wr_acc1 && bus.write_en2 && (count_q < CNT_DEPTH_M1);
        rd_acc1 = bus.read_en1 && (count_q != '0);
        rd_acc2 = rd_acc1 && bus.read_en2 && (count_q >= CNT_TWO);
        n_wr    = slots_taken(wr_acc1, wr_acc2);
        n_rd    = slots_taken(rd_acc1, rd_acc2);
        head_d  = head_q + PTR_W'(n_rd);
        tail_d  = tail_q + PTR_W'(n_wr);
        count_d = count_q + CNT_W'(n_wr) - CNT_W'(n_rd);
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_p1 = head_q + PTR_W'(1);

    // A flushing cycle leaves storage untouched, so its writes are suppressed here.
    fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i    (clk),
        .we1_i    (wr_acc1 && !bus.flush),
        .we2_i    (wr_acc2 && !bus.flush),
        .waddr_i  (tail_q),
        .wdata1_i (bus.write_data1),
        .wdata2_i (bus.write_data2),
        .raddr1_i (head_q),
        .raddr2_i (head_p1),
        .rdata1_o (ram_rd1),
        .rdata2_o (ram_rd2)
    );

    assign bus.read_valid1 = (count_q != '0);
    assign bus.read_valid2 = (count_q >= CNT_TWO);
    assign bus.empty       = (count_q == '0);
    assign bus.full        = (count_q >= CNT_DEPTH_M1);
    assign bus.count       = count_q;
    assign bus.read_data1  = bus.read_valid1 ? ram_rd1 : '0;
    assign bus.read_data2  = bus.read_valid2 ? ram_rd2 : '0;

    a_write_pair : assert property (@(posedge clk) disable iff (rst)
        !(bus.write_en2 && !bus.write_en1));
    a_read_pair : assert property (@(posedge clk) disable iff (rst)
        !(bus.read_en2 && !bus.read_en1));

endmodule

// File: doc/inst_fifo.md
# inst_fifo

Dual-issue instruction buffer between the fetch stage and decode. Each cycle it accepts up to two fetched instructions, tagged with their PC and TLB status, in program order. It presents the two oldest entries to decode in show-ahead form and retires up to two per cycle. Its `full` output is the fetch stage's `fifo_full` stall input, and `flush` discards all contents on branch or exception redirect.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥4.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: discard all entries (branch/exception redirect).
- `write_en1` in 1: write slot 1 valid (older instruction).
- `write_en2` in 1: write slot 2 valid; legal only with `write_en1`.
- `write_data1`, `write_data2` in `fetch_entry_t`: entries to write.
- `read_en1` in 1: decode consumes head entry.
- `read_en2` in 1: decode consumes head+1; legal only with `read_en1`.
- `read_data1`, `read_data2` out `fetch_entry_t`: head and head+1 entries; all-zero when the matching valid is low.
- `read_valid1` out 1: count ≥ 1.
- `read_valid2` out 1: count ≥ 2.
- `empty` out 1: count == 0.
- `full` out 1: count ≥ DEPTH−1, i.e. fewer than two free slots.
- `count` out $clog2(DEPTH)+1: occupied entries.

## Operation
- Storage: DEPTH × `fetch_entry_t` circular buffer, with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered `count`.
- Write acceptance uses the registered count only; same-cycle reads never free space for writes.
  - Slot 1 is accepted if count < DEPTH.
  - Slot 2 is accepted if slot 1 is accepted and count < DEPTH−1.
  - Rejected writes are dropped silently.
  - `write_en2` without `write_en1` is ignored and flagged by assertion.
- Accepted slot 1 is stored at tail and slot 2 at tail+1; tail advances by the number accepted.
- Read acceptance:
  - `read_en1` is honoured if count ≥ 1.
  - `read_en2` is honoured if `read_en1` is honoured and count ≥ 2.
  - `read_en2` alone is ignored and flagged by assertion.
  - Head advances by the number honoured.
- Count update: count_next = count + writes_accepted − reads_honoured (range 0..DEPTH, never wraps).
- Outputs: `read_data1`/`read_data2` are combinational from storage at head and head+1 (mod DEPTH), gated to zero when invalid. There is no write-to-read bypass.
- `flush` has priority over all same-cycle reads and writes. On the next edge head, tail and count become 0; storage is untouched.
- Reset: head = tail = count = 0. Resulting outputs are `empty`=1, `full`=0, `read_valid1`=`read_valid2`=0, read data all-zero. Storage is not reset.
- Reset mid-operation clears state immediately (asynchronous); outputs take reset values without waiting for a clock edge.

## Timing
- Write-to-read latency is 1 cycle: an entry written at edge N is visible on `read_data1` after edge N and can be consumed in cycle N+1.
- Read consumption takes effect at the edge; the next entries appear in the following cycle.
- `full`, `empty`, valids and `count` are registered-count functions, stable for the whole cycle.
- Fetch observes `full` in the same cycle and holds its PC. A fetch issued while `full` is high is lost, so fetch must not assert write enables while `full` is high.
- After `flush` at edge N, `empty`=1 in cycle N+1, and writes in cycle N+1 are accepted normally.

## Structure
- Shared CPU package:
  - `fetch_entry_t` packed struct: `pc`[31:0], `inst`[31:0], `tlb_miss`, `tlb_illegal`, `tlb_invalid` (67 bits).
  - `FETCH_WIDTH` = 2.
- One sub-module, `fifo_ram`: DEPTH-entry storage with two write ports (consecutive addresses) and two asynchronous read ports, no reset.
- Pointer, count and acceptance logic live in `inst_fifo`.

## Test plan
- Reset, then dual writes of PCs 0xbfc00000/0xbfc00004 → next cycle `read_valid1`=`read_valid2`=1 with those PCs, `count`=2, `empty`=0.
- Fill with 15 entries (DEPTH=16) → `full`=1. A dual write is then applied: slot 1 is stored, slot 2 is dropped, and `count`=16.
- Simultaneous dual write and dual read at count=4 for 20 cycles → `count` stays 4, pointers wrap, and PCs exit strictly in written order.
- `read_en2` with count=1 → only one entry consumed, `count`=0, `empty`=1. `read_en2` without `read_en1` → nothing consumed and the assertion fires.
- `flush` with count=9 together with a dual write and a dual read → next cycle `count`=0, `empty`=1, read data zero. The following write of PC 0x80000180 appears as head.
- Assert `rst` asynchronously between edges at count=7 → outputs return to reset values immediately. After release, the first write behaves normally.
